mult_seq_ctrl: RTL and testbench

Hardwired control unit for the shift-and-add multiplier datapath, i.e. the 3-bit Q shift register plus the A accumulator and M register. A Moore FSM with an iteration counter drives the load, clear, add and shift strobes. It runs N add/shift iterations per multiply and signals completion with a one-cycle `fin` pulse.

---
 rtl/mult_seq_ctrl_if.sv | 39 +++
 rtl/mult_seq_ctrl.sv | 115 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between the shift-and-add multiplier sequencer and its datapath.
// MULT_SEQ_CTRL_ABORT_EN adds the synchronous abort request.
`timescale 1ns/1ps
interface mult_seq_ctrl_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned CW = $clog2(N + 1);

  logic          start;
  logic          q0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
  logic          abort;
`endif
  logic          CargaM;
  logic          CargaQ;
  logic          ClearA;
  logic          CargaA;
  logic          DesplazaA;
  logic          DesplazaQ;
  logic          busy;
  logic          fin;
  logic [CW-1:0] cnt;

  modport master (
`ifdef MULT_SEQ_CTRL_ABORT_EN
    output abort,
`endif
    output start, q0,
    input  CargaM, CargaQ, ClearA, CargaA, DesplazaA, DesplazaQ, busy, fin, cnt
  );

  modport slave (
`ifdef MULT_SEQ_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, q0,
    output CargaM, CargaQ, ClearA, CargaA, DesplazaA, DesplazaQ, busy, fin, cnt
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Moore sequencer for an N-bit shift-and-add multiplier: load, N x (eval, [add], shift), done.
// Define MULT_SEQ_CTRL_ABORT_EN to add a synchronous abort that returns to IDLE from any busy state.
`timescale 1ns/1ps
module mult_seq_ctrl #(
  parameter int unsigned N = 3
) (
  input  logic           clk,
  input  logic           reset,
  mult_seq_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic w_carga_m, w_carga_q, w_clear_a, w_carga_a;
  logic w_desplaza_a, w_desplaza_q, w_busy, w_fin;

  // State and iteration counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter update; unused encodings fall back to IDLE
  always_comb begin
    w_next_state = S_IDLE;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE:  w_next_state = bus.start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        w_cnt_next   = CW'(N);
        w_next_state = S_EVAL;
      end
      S_EVAL:  w_next_state = bus.q0 ? S_ADD : S_SHIFT;
      S_ADD:   w_next_state = S_SHIFT;
      S_SHIFT: begin
        w_cnt_next   = CW'(r_cnt - CW'(1));
        w_next_state = (r_cnt == CW'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
`ifdef MULT_SEQ_CTRL_ABORT_EN
    if (bus.abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_cnt_next   = '0;
    end
`endif
  end

  // Strobes decoded from the current state only
  always_comb begin
    w_carga_m    = 1'b0;
    w_carga_q    = 1'b0;
    w_clear_a    = 1'b0;
    w_carga_a    = 1'b0;
    w_desplaza_a = 1'b0;
    w_desplaza_q = 1'b0;
    w_busy       = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_carga_m = 1'b1;
        w_carga_q = 1'b1;
        w_clear_a = 1'b1;
        w_busy    = 1'b1;
      end
      S_EVAL:  w_busy = 1'b1;
      S_ADD: begin
        w_carga_a = 1'b1;
        w_busy    = 1'b1;
      end
      S_SHIFT: begin
        w_desplaza_a = 1'b1;
        w_desplaza_q = 1'b1;
        w_busy       = 1'b1;
      end
      S_DONE: begin
        w_fin  = 1'b1;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.CargaM    = w_carga_m;
  assign bus.CargaQ    = w_carga_q;
  assign bus.ClearA    = w_clear_a;
  assign bus.CargaA    = w_carga_a;
  assign bus.DesplazaA = w_desplaza_a;
  assign bus.DesplazaQ = w_desplaza_q;
  assign bus.busy      = w_busy;
  assign bus.fin       = w_fin;
  assign bus.cnt       = r_cnt;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural shift-and-add datapath closing the q0 loop.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.N(N)) bus ();
  mult_seq_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [N-1:0] m_in, q_in, m_r, q_r, a_r;
  logic         c_r;
  logic [7:0]   trace   [64];
  int           cnt_tr  [64];
  logic [7:0]   exp_tr  [10];
  int           exp_cnt [10];

  // Datapath model: M, Q, A with carry, driven by the strobes
  assign bus.q0 = q_r[0];
  always @(posedge clk) begin
    if (bus.CargaM) m_r <= m_in;
    if (bus.CargaQ) q_r <= q_in;
    if (bus.ClearA) begin a_r <= '0; c_r <= 1'b0; end
    if (bus.CargaA) {c_r, a_r} <= {1'b0, a_r} + {1'b0, m_r};
    if (bus.DesplazaA) begin c_r <= 1'b0; a_r <= {c_r, a_r[N-1:1]}; end
    if (bus.DesplazaQ) q_r <= {a_r[0], q_r[N-1:1]};
  end

  function automatic logic [7:0] outs();
    return {bus.CargaM, bus.CargaQ, bus.ClearA, bus.CargaA,
            bus.DesplazaA, bus.DesplazaQ, bus.busy, bus.fin};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: one-cycle start, 1: start left high, 2: start toggled while busy
  task automatic run_mult(input logic [N-1:0] m, input logic [N-1:0] q, input int mode,
                          input string tag);
    int cyc = 0, adds = 0, shifts = 0, fins = 0, fin_at = 0;
    bit excl_ok = 1'b1, done = 1'b0;
    @(negedge clk);
    m_in = m; q_in = q; bus.start = 1'b1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mode == 0 && cyc == 1) bus.start = 1'b0;
      if (mode == 2) bus.start = (cyc >= 2 && cyc <= 7) ? ~cyc[0] : 1'b0;
      trace[cyc]  = outs();
      cnt_tr[cyc] = int'(bus.cnt);
      if (bus.CargaA) adds++;
      if (bus.DesplazaQ) shifts++;
      if (bus.CargaA && (bus.DesplazaA || bus.DesplazaQ)) excl_ok = 1'b0;
      if (cyc != 1 && (bus.CargaM || bus.CargaQ || bus.ClearA)) excl_ok = 1'b0;
      if (bus.fin) begin fins++; fin_at = cyc; done = 1'b1; end
    end
    chk({tag, "_fin_cycle"}, fin_at, 2 * N + $countones(q) + 2);
    chk({tag, "_adds"}, adds, $countones(q));
    chk({tag, "_shifts"}, shifts, N);
    chk({tag, "_excl"}, 32'(excl_ok), 1);
    chk({tag, "_product"}, 32'({a_r, q_r}), int'(m) * int'(q));
    if (mode == 2) begin
      repeat (4) begin
        @(negedge clk);
        if (bus.fin) fins++;
      end
      chk({tag, "_fin_pulses"}, fins, 1);
      chk({tag, "_idle_after"}, 32'(bus.busy), 0);
    end
  endtask

  initial begin
    int k;
    bit seen;
    exp_tr  = '{8'b1110_0010, 8'b0000_0010, 8'b0001_0010, 8'b0000_1110, 8'b0000_0010,
                8'b0000_1110, 8'b0000_0010, 8'b0001_0010, 8'b0000_1110, 8'b0000_0011};
    exp_cnt = '{0, 3, 3, 3, 2, 2, 1, 1, 1, 0};
    reset = 1'b0; bus.start = 1'b0; m_in = '0; q_in = '0;
`ifdef MULT_SEQ_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1;
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_cnt", 32'(bus.cnt), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_mult(3'd5, 3'b101, 0, "q101");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("q101_outs_c%0d", i + 1), 32'(trace[i + 1]), 32'(exp_tr[i]));
      chk($sformatf("q101_cnt_c%0d", i + 1), cnt_tr[i + 1], exp_cnt[i]);
    end

    run_mult(3'd5, 3'd6, 0, "m5q6");
    run_mult(3'd3, 3'b000, 0, "q000");
    run_mult(3'd2, 3'b111, 0, "q111");
    run_mult(3'd6, 3'b011, 2, "toggle");

    run_mult(3'd4, 3'd5, 1, "hold");
    @(negedge clk);
    chk("hold_idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("hold_reload", 32'(bus.CargaM), 1);
    bus.start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.fin) seen = 1'b1;
    end
    chk("hold_second_fin", 32'(seen), 1);
    chk("hold_second_product", 32'({a_r, q_r}), 20);

    // Asynchronous reset while in ADD
    @(negedge clk);
    m_in = 3'd3; q_in = 3'b101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_in_add", 32'(bus.CargaA), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrun_reset_outs", 32'(outs()), 0);
    chk("midrun_reset_cnt", 32'(bus.cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 0);
    chk("post_reset_cnt", 32'(bus.cnt), 0);

`ifdef MULT_SEQ_CTRL_ABORT_EN
    // Abort in the second EVAL of Q=101
    @(negedge clk);
    m_in = 3'd5; q_in = 3'b101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_eval", 32'(outs()), 32'(8'b0000_0010));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_cnt", 32'(bus.cnt), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.fin) seen = 1'b1;
    end
    chk("abort_no_fin", 32'(seen), 0);
    run_mult(3'd5, 3'b101, 0, "after_abort");
`endif

    for (int m = 0; m < 8; m++)
      for (int q = 0; q < 8; q++)
        run_mult(3'(m), 3'(q), 0, $sformatf("sweep_m%0d_q%0d", m, q));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
